// File: rtl/rst_seq_ctrl.sv
// Reset sequencer for a single clock domain.
// Merges synchronized active-low reset sources with a software reset
// request, holds every block in reset until the request has been clean
// for HOLD_CYCLES, then releases the block resets one at a time
// (bit 0 first) with RELEASE_GAP cycles between releases.
// RST_CAUSE keeps a sticky record of which requests were seen.
//
// Handshake: there is no valid/ready pair. Every output is a plain
// registered level that may be sampled on any cycle.
module rst_seq_ctrl #(
  parameter int NUM_SRC     = 2,
  parameter int SYNC_STAGES = 2,
  parameter int NUM_OUT     = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int RELEASE_GAP = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_SRC-1:0] SRC_RST_N,
  input  logic               SW_RST,
  input  logic               CAUSE_CLR,
  output logic [NUM_OUT-1:0] SYNC_RST,
  output logic               RST_DONE,
  output logic [NUM_SRC:0]   RST_CAUSE,
  output logic [1:0]         DBG_STATE
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int GW = (RELEASE_GAP > 1) ? $clog2(RELEASE_GAP) : 1;
  localparam int IW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(RELEASE_GAP - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_OUT - 1);

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_RELEASE = 2'd1,
    S_RUN     = 2'd2
  } state_t;

  // Synchronizer chains, one stage per array entry; the last stage is the usable value.
  logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
  logic [NUM_SRC-1:0] src_sync;

  // Marks when the chains hold real samples instead of their reset contents.
  logic [SYNC_STAGES-1:0] prime_q;
  logic                   primed;

  state_t               state_q, state_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic [GW-1:0]        gap_q, gap_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [NUM_OUT-1:0]   sync_rst_q, sync_rst_d;
  logic                 done_q, done_d;
  logic [NUM_SRC:0]     cause_q, cause_d;
  logic                 req;
  logic [NUM_SRC-1:0]   src_req;

  assign src_sync = sync_q[SYNC_STAGES-1];
  assign primed   = prime_q[SYNC_STAGES-1];

  // Shift each external request through its synchronizer; reset reads as asserted.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      prime_q <= '0;
    end else begin
      sync_q[0] <= SRC_RST_N;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prime_q <= {prime_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Request and cause logic. The chain's reset contents hold the sequencer
  // in reset but are not a real event, so they are kept out of the cause record.
  always_comb begin
    req     = (|(~src_sync)) | SW_RST;
    src_req = primed ? ~src_sync : '0;
    cause_d = (CAUSE_CLR ? '0 : cause_q) | {SW_RST, src_req};
  end

  // Next-state and next-output logic for the HOLD/RELEASE/RUN sequence.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    gap_d      = gap_q;
    idx_d      = idx_q;
    sync_rst_d = sync_rst_q;
    done_d     = done_q;
    case (state_q)
      S_HOLD: begin
        if (req) begin
          hold_d = '0;
        end else if (hold_q == HOLD_LAST) begin
          sync_rst_d[0] = 1'b1;
          idx_d         = IW'(1);
          gap_d         = '0;
          hold_d        = '0;
          if (NUM_OUT == 1) begin
            done_d  = 1'b1;
            state_d = S_RUN;
          end else begin
            state_d = S_RELEASE;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_RELEASE: begin
        if (req) begin
          // A new request beats any release due on this edge.
          sync_rst_d = '0;
          done_d     = 1'b0;
          hold_d     = '0;
          gap_d      = '0;
          idx_d      = '0;
          state_d    = S_HOLD;
        end else if (gap_q == GAP_LAST) begin
          sync_rst_d[idx_q] = 1'b1;
          gap_d             = '0;
          if (idx_q == IDX_LAST) begin
            done_d  = 1'b1;
            state_d = S_RUN;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      S_RUN: begin
        if (req) begin
          sync_rst_d = '0;
          done_d     = 1'b0;
          hold_d     = '0;
          gap_d      = '0;
          idx_d      = '0;
          state_d    = S_HOLD;
        end
      end
      default: begin
        sync_rst_d = '0;
        done_d     = 1'b0;
        hold_d     = '0;
        gap_d      = '0;
        idx_d      = '0;
        state_d    = S_HOLD;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= S_HOLD;
      hold_q     <= '0;
      gap_q      <= '0;
      idx_q      <= '0;
      sync_rst_q <= '0;
      done_q     <= 1'b0;
      cause_q    <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      gap_q      <= gap_d;
      idx_q      <= idx_d;
      sync_rst_q <= sync_rst_d;
      done_q     <= done_d;
      cause_q    <= cause_d;
    end
  end

  assign SYNC_RST  = sync_rst_q;
  assign RST_DONE  = done_q;
  assign RST_CAUSE = cause_q;
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Testbench for rst_seq_ctrl with default parameters.
// Expected output words are tagged with the clock edge count at which they
// must hold; a monitor on the falling edge pops and compares them.
module tb_rst_seq_ctrl;

  localparam int W = 23;  // {edge[15:0], sync_rst[2:0], done, cause[2:0]}

  // Clock and reset
  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [1:0] SRC_RST_N = 2'b11;
  logic       SW_RST = 1'b0;
  logic       CAUSE_CLR = 1'b0;
  logic [2:0] SYNC_RST;
  logic       RST_DONE;
  logic [2:0] RST_CAUSE;
  logic [1:0] DBG_STATE;

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  rst_seq_ctrl dut (
    .CLK       (CLK),
    .RST       (RST),
    .SRC_RST_N (SRC_RST_N),
    .SW_RST    (SW_RST),
    .CAUSE_CLR (CAUSE_CLR),
    .SYNC_RST  (SYNC_RST),
    .RST_DONE  (RST_DONE),
    .RST_CAUSE (RST_CAUSE),
    .DBG_STATE (DBG_STATE)
  );

  // Scoreboard
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // Driver tasks
  task automatic push_exp(input int c, input logic [2:0] sr, input logic d, input logic [2:0] ca);
    logic [15:0] c16;
    c16 = c[15:0];
    exp_q.push_back({c16, sr, d, ca});
  endtask

  task automatic go_to(input int c);
    while (cyc < c) @(negedge CLK);
  endtask

  // Monitor
  logic [W-1:0] mon_e;
  logic [15:0]  mon_c;
  logic [15:0]  cur_c;
  logic         therm_ok;

  always @(negedge CLK) begin
    checks++;
    therm_ok = 1'b1;
    for (int k = 1; k < 3; k++) if (SYNC_RST[k] && !SYNC_RST[k-1]) therm_ok = 1'b0;
    if (!therm_ok) begin
      errors++;
      $display("FAIL thermometer edge=%0d sync_rst=%b required thermometer code", cyc, SYNC_RST);
    end
    if (exp_q.size() > 0) begin
      mon_e = exp_q[0];
      mon_c = mon_e[22:7];
      cur_c = cyc[15:0];
      if (mon_c == cur_c) begin
        void'(exp_q.pop_front());
        checks++;
        if ({SYNC_RST, RST_DONE, RST_CAUSE} !== mon_e[6:0]) begin
          errors++;
          $display("FAIL outputs edge=%0d got sync_rst=%b done=%b cause=%b exp sync_rst=%b done=%b cause=%b",
                   cyc, SYNC_RST, RST_DONE, RST_CAUSE, mon_e[6:4], mon_e[3], mon_e[2:0]);
        end
      end else if (mon_c < cur_c) begin
        void'(exp_q.pop_front());
        checks++;
        errors++;
        $display("FAIL missed_slot edge=%0d got edge=%0d exp edge=%0d", mon_c, cyc, mon_c);
      end
    end
  end

  // Stimulus
  initial begin
    // 1: power-up sequence, RST held low for edges 1-2, first free edge is 3
    push_exp(1,   3'b000, 1'b0, 3'b000);
    push_exp(2,   3'b000, 1'b0, 3'b000);
    push_exp(19,  3'b000, 1'b0, 3'b000);
    push_exp(20,  3'b001, 1'b0, 3'b000);
    push_exp(24,  3'b011, 1'b0, 3'b000);
    push_exp(28,  3'b111, 1'b1, 3'b000);
    go_to(2);
    RST = 1'b1;

    // 2: source 1 low for five edges while running
    go_to(29);
    push_exp(30,  3'b111, 1'b1, 3'b000);
    push_exp(32,  3'b111, 1'b1, 3'b000);
    push_exp(33,  3'b000, 1'b0, 3'b010);
    push_exp(52,  3'b000, 1'b0, 3'b010);
    push_exp(53,  3'b001, 1'b0, 3'b010);
    push_exp(57,  3'b011, 1'b0, 3'b010);
    go_to(30);
    SRC_RST_N = 2'b01;
    go_to(35);
    SRC_RST_N = 2'b11;

    // 3: one-cycle software reset while partially released
    go_to(56);
    push_exp(58,  3'b011, 1'b0, 3'b010);
    push_exp(59,  3'b000, 1'b0, 3'b110);
    go_to(58);
    SW_RST = 1'b1;
    go_to(59);
    SW_RST = 1'b0;

    // 5: cause clear alone, then clear together with a software request
    push_exp(60,  3'b000, 1'b0, 3'b110);
    push_exp(61,  3'b000, 1'b0, 3'b000);
    push_exp(62,  3'b000, 1'b0, 3'b100);
    go_to(60);
    CAUSE_CLR = 1'b1;
    go_to(61);
    SW_RST = 1'b1;
    go_to(62);
    SW_RST = 1'b0;
    CAUSE_CLR = 1'b0;

    // 4: one-cycle glitch on source 0 at hold count 10 restarts the hold
    push_exp(74,  3'b000, 1'b0, 3'b100);
    push_exp(75,  3'b000, 1'b0, 3'b101);
    push_exp(78,  3'b000, 1'b0, 3'b101);
    push_exp(90,  3'b000, 1'b0, 3'b101);
    push_exp(91,  3'b001, 1'b0, 3'b101);
    push_exp(95,  3'b011, 1'b0, 3'b101);
    push_exp(96,  3'b011, 1'b0, 3'b101);
    go_to(72);
    SRC_RST_N = 2'b10;
    go_to(73);
    SRC_RST_N = 2'b11;

    // 6: RST mid-sequence, then a full restart
    go_to(94);
    push_exp(97,  3'b000, 1'b0, 3'b000);
    push_exp(98,  3'b000, 1'b0, 3'b000);
    push_exp(115, 3'b000, 1'b0, 3'b000);
    push_exp(116, 3'b001, 1'b0, 3'b000);
    push_exp(120, 3'b011, 1'b0, 3'b000);
    push_exp(124, 3'b111, 1'b1, 3'b000);
    go_to(96);
    RST = 1'b0;
    go_to(98);
    RST = 1'b1;

    // Final report
    go_to(127);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d entries left exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
